// File: rtl/load_unit_ctrl.sv
// Load sequencer for the multicycle datapath: issues one word-aligned read,
// waits MEM_LAT cycles, then extracts and extends the addressed byte/halfword/word.
module load_unit_ctrl #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] mem_rdata,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] result
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_CAPTURE,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                mem_rd_q, mem_rd_d;
  logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                req_bad;
  logic [7:0]          lane_b;
  logic [15:0]         lane_h;
  logic [DATA_W-1:0]   load_data;

  // Request screening: illegal opcode or misaligned halfword/word
  always_comb begin
    req_bad = 1'b0;
    case (op)
      OP_LB, OP_LBU: req_bad = 1'b0;
      OP_LH, OP_LHU: req_bad = addr[0];
      OP_LW:         req_bad = (addr[1:0] != 2'b00);
      default:       req_bad = 1'b1;
    endcase
  end

  // Lane select and size extension of the returned word
  always_comb begin
    lane_b    = 8'h00;
    lane_h    = 16'h0000;
    load_data = mem_rdata;
    case (addr_q[1:0])
      2'd0:    lane_b = mem_rdata[7:0];
      2'd1:    lane_b = mem_rdata[15:8];
      2'd2:    lane_b = mem_rdata[23:16];
      default: lane_b = mem_rdata[31:24];
    endcase
    lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_q)
      OP_LB:   load_data = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  load_data = {24'h000000, lane_b};
      OP_LH:   load_data = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  load_data = {16'h0000, lane_h};
      default: load_data = mem_rdata;
    endcase
  end

  // Next state; outputs are decoded from the next state so they register with it
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          addr_d  = addr;
          state_d = req_bad ? S_ERR : S_READ;
        end
      end
      S_READ: begin
        if (MEM_LAT == 1) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d   = CNT_W'(MEM_LAT - 2);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_CAPTURE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_CAPTURE: begin
        result_d = load_data;
        state_d  = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    mem_rd_d   = (state_d == S_READ);
    mem_addr_d = (state_d == S_READ) ? {addr_d[31:2], 2'b00} : '0;
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE) || (state_d == S_ERR);
    err_d      = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign result   = result_q;

endmodule

// File: tb/tb_load_unit_ctrl.sv
// Bench for load_unit_ctrl: instance 0 uses MEM_LAT=1, instance 1 uses MEM_LAT=4,
// each with a latency-accurate memory model; expected results go through a scoreboard.
module tb_load_unit_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        rst_v;
  logic [1:0]        start_v;
  logic [1:0][2:0]   op_v;
  logic [1:0][31:0]  addr_v;
  logic [1:0][31:0]  mem_rdata_v;
  logic [1:0]        mem_rd_v;
  logic [1:0][31:0]  mem_addr_v;
  logic [1:0]        busy_v;
  logic [1:0]        done_v;
  logic [1:0]        err_v;
  logic [1:0][31:0]  result_v;

  logic [31:0] mem [0:1][0:255];

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        err;
    logic [31:0] res;
  } exp_t;
  exp_t sb[$];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 1 : 4;
    int unsigned age = 0;
    logic [31:0] pend;

    load_unit_ctrl #(.MEM_LAT(LAT)) u_dut (
      .clk      (clk),
      .reset_n  (rst_v[g]),
      .start    (start_v[g]),
      .op       (op_v[g]),
      .addr     (addr_v[g]),
      .mem_rdata(mem_rdata_v[g]),
      .mem_rd   (mem_rd_v[g]),
      .mem_addr (mem_addr_v[g]),
      .busy     (busy_v[g]),
      .done     (done_v[g]),
      .err      (err_v[g]),
      .result   (result_v[g])
    );

    // Read data valid only in the cycle exactly LAT cycles after the mem_rd cycle
    always @(posedge clk) begin
      if (mem_rd_v[g]) begin
        age  <= 1;
        pend <= mem_addr_v[g];
      end else if (age != 0 && age < 255) begin
        age <= age + 1;
      end
    end
    assign mem_rdata_v[g] = (age == LAT) ? mem[g][pend[9:2]] : 32'hDEADBEEF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One load; spur>0 raises start again for one cycle at that cycle index
  task automatic run_load(input int i, input logic [2:0] o, input logic [31:0] a,
                          input logic e, input logic [31:0] r, input int dn,
                          input int spur, input string tag);
    int done_n, ndone, nrd, nbusy, addr_bad;
    logic [31:0] rd_addr;
    exp_t x;
    done_n = 0; ndone = 0; nrd = 0; nbusy = 0; addr_bad = 0; rd_addr = '0;
    x.err = e;
    x.res = r;
    sb.push_back(x);
    @(negedge clk);
    op_v[i] = o; addr_v[i] = a; start_v[i] = 1'b1;
    for (int n = 1; n <= dn + 4; n++) begin
      @(negedge clk);
      start_v[i] = (n == spur);
      op_v[i]    = 3'b010;
      addr_v[i]  = 32'hFFFF_FFFC;
      if (busy_v[i]) nbusy++;
      if (mem_rd_v[i]) begin
        nrd++;
        rd_addr = mem_addr_v[i];
      end else if (mem_addr_v[i] != 32'h0) begin
        addr_bad++;
      end
      if (done_v[i]) begin
        ndone++;
        if (done_n == 0) done_n = n;
        chk({tag, " sb_depth"}, 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
          x = sb.pop_front();
          chk({tag, " err"}, {31'b0, err_v[i]}, {31'b0, x.err});
          chk({tag, " result"}, result_v[i], x.res);
        end
      end
    end
    start_v[i] = 1'b0;
    chk({tag, " done_cycle"}, 32'(done_n), 32'(dn));
    chk({tag, " done_count"}, 32'(ndone), 32'd1);
    chk({tag, " rd_count"}, 32'(nrd), e ? 32'd0 : 32'd1);
    chk({tag, " busy_cycles"}, 32'(nbusy), 32'(dn));
    chk({tag, " addr_idle"}, 32'(addr_bad), 32'd0);
    chk({tag, " busy_end"}, {31'b0, busy_v[i]}, 32'd0);
    if (!e) chk({tag, " mem_addr"}, rd_addr, {a[31:2], 2'b00});
  endtask

  initial begin
    int ndone;
    logic [31:0] dmask, rmask;
    exp_t x;
    mem[0][8'h40] = 32'h8040C0FF;
    mem[1][8'h80] = 32'h12345678;
    mem[1][8'h40] = 32'h7F000000;
    rst_v = 2'b00; start_v = 2'b00; op_v = '0; addr_v = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst mem_rd", {31'b0, mem_rd_v[i]}, 32'd0);
      chk("rst mem_addr", mem_addr_v[i], 32'd0);
      chk("rst busy", {31'b0, busy_v[i]}, 32'd0);
      chk("rst done", {31'b0, done_v[i]}, 32'd0);
      chk("rst err", {31'b0, err_v[i]}, 32'd0);
      chk("rst result", result_v[i], 32'd0);
    end
    rst_v = 2'b11;

    // MEM_LAT=1 lane selection and extension
    run_load(0, 3'b000, 32'h100, 1'b0, 32'hFFFFFFFF, 3, 0, "lb100");
    run_load(0, 3'b100, 32'h101, 1'b0, 32'h000000C0, 3, 0, "lbu101");
    run_load(0, 3'b001, 32'h102, 1'b0, 32'hFFFF8040, 3, 0, "lh102");
    run_load(0, 3'b101, 32'h100, 1'b0, 32'h0000C0FF, 3, 0, "lhu100");
    run_load(0, 3'b010, 32'h100, 1'b0, 32'h8040C0FF, 3, 0, "lw100");

    // Error path keeps the previous result
    run_load(0, 3'b010, 32'h102, 1'b1, 32'h8040C0FF, 1, 0, "lw102_err");
    run_load(0, 3'b001, 32'h101, 1'b1, 32'h8040C0FF, 1, 0, "lh101_err");
    run_load(0, 3'b011, 32'h100, 1'b1, 32'h8040C0FF, 1, 0, "op011_err");

    // Back-to-back with start held high: done every 4 cycles
    for (int k = 0; k < 4; k++) begin
      x.err = 1'b0;
      x.res = 32'h8040C0FF;
      sb.push_back(x);
    end
    dmask = '0; rmask = '0;
    @(negedge clk);
    op_v[0] = 3'b010; addr_v[0] = 32'h100; start_v[0] = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (n == 16) start_v[0] = 1'b0;
      if (mem_rd_v[0]) rmask[n] = 1'b1;
      if (done_v[0]) begin
        dmask[n] = 1'b1;
        if (sb.size() > 0) begin
          x = sb.pop_front();
          chk("b2b result", result_v[0], x.res);
          chk("b2b err", {31'b0, err_v[0]}, {31'b0, x.err});
        end
      end
    end
    chk("b2b done_mask", dmask, 32'h00008888);
    chk("b2b rd_mask", rmask, 32'h00002222);
    chk("b2b sb_left", 32'(sb.size()), 32'd0);
    sb.delete();

    // MEM_LAT=4 with a start pulse during WAIT
    run_load(1, 3'b010, 32'h200, 1'b0, 32'h12345678, 6, 3, "lat4_lw200");

    // Async reset mid-WAIT aborts the load
    @(negedge clk);
    op_v[1] = 3'b010; addr_v[1] = 32'h200; start_v[1] = 1'b1;
    @(negedge clk);
    start_v[1] = 1'b0;
    @(negedge clk);
    chk("abort busy_before", {31'b0, busy_v[1]}, 32'd1);
    #2 rst_v[1] = 1'b0;
    #1;
    chk("abort mem_rd", {31'b0, mem_rd_v[1]}, 32'd0);
    chk("abort mem_addr", mem_addr_v[1], 32'd0);
    chk("abort busy", {31'b0, busy_v[1]}, 32'd0);
    chk("abort done", {31'b0, done_v[1]}, 32'd0);
    chk("abort err", {31'b0, err_v[1]}, 32'd0);
    chk("abort result", result_v[1], 32'd0);
    ndone = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (done_v[1]) ndone++;
    end
    rst_v[1] = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (done_v[1]) ndone++;
    end
    chk("abort no_done", 32'(ndone), 32'd0);
    run_load(1, 3'b000, 32'h103, 1'b0, 32'h0000007F, 6, 0, "lat4_lb103");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1);
  end

endmodule

// File: doc/load_unit_ctrl.md
Name: load_unit_ctrl

Overview:
Sequences a single memory load for the MIPS multicycle datapath. It accepts a load request (LB/LBU/LH/LHU/LW) and issues the word-aligned memory read. It waits a fixed memory latency, then selects the addressed byte or halfword lane and sign- or zero-extends it to 32 bits. It returns the result with a one-cycle done pulse. It sits between the main control FSM and the memory/MDR path and owns load-size extension, so the control FSM only issues start and waits for done.

Parameters:
MEM_LAT, 1, cycles from mem_rd asserted to mem_rdata valid; legal range 1..15.

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  request pulse; sampled only in IDLE
op  input  3  000=LB, 001=LH, 010=LW, 100=LBU, 101=LHU; other codes are illegal
addr  input  32  byte address of the load, sampled with start
mem_rdata  input  32  memory read data, little-endian byte lanes
mem_rd  output  1  memory read strobe, high exactly one cycle per load
mem_addr  output  32  word address {addr_q[31:2],2'b00}; 0 when not in READ
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse
err  output  1  valid with done; 1 = misaligned or illegal op
result  output  32  extended load data; held until the next successful load

Behaviour:
- Reset (async, reset_n=0): state=IDLE; mem_rd=0, mem_addr=0, busy=0, done=0, err=0, result=0; counter=0. Reset during any state aborts the load immediately: mem_rd drops without waiting for a clock, and no done is issued.
- States: IDLE, READ, WAIT, CAPTURE, DONE, ERR.
- IDLE: if start=1, latch op_q=op and addr_q=addr.
  - Illegal op, LH/LHU with addr[0]=1, or LW with addr[1:0]!=0 -> ERR.
  - Otherwise -> READ.
- ERR (1 cycle): done=1, err=1, result unchanged, mem_rd never asserted -> IDLE.
- READ (1 cycle): mem_rd=1, mem_addr valid.
  - MEM_LAT=1 -> CAPTURE.
  - Otherwise load counter=MEM_LAT-2 and go to WAIT.
- WAIT: decrement the counter each cycle; at counter==0 -> CAPTURE. WAIT lasts MEM_LAT-1 cycles.
- CAPTURE: mem_rdata is valid this cycle. On the clock edge, load result and go to DONE. Result rules:
  - LB/LBU: byte lane addr_q[1:0] (lane 0 = bits 7:0).
  - LH/LHU: halfword addr_q[1] (0 = bits 15:0).
  - LB/LH sign-extend from the lane MSB; LBU/LHU zero-extend.
  - LW: word passed unchanged.
- DONE (1 cycle): done=1, err=0 -> IDLE.
- Latency: with start sampled at edge s, mem_rd is high in cycle s+1 and done is high in cycle s+MEM_LAT+2. The error path gives done in cycle s+1.
- busy=0 only in IDLE. start while busy=1, including the DONE/ERR cycle, is ignored and not queued. A new start is accepted in the first IDLE cycle after done, so back-to-back loads have one idle gap.
- op and addr are don't-care outside the start sample; changes mid-load have no effect.
- result is never modified by ERR or by a reset-free abort (no such abort exists); only reset clears it.
- done and err are registered state decodes and are glitch-free.

Test Plan:
- MEM_LAT=1, mem word at 0x100 = 0x8040C0FF; LB addr 0x100 -> mem_rd in cycle s+1 with mem_addr=0x100; done in cycle s+3; result=0xFFFFFFFF, err=0.
- Same word: LBU 0x101 -> 0x000000C0; LH 0x102 -> 0xFFFF8040; LHU 0x100 -> 0x0000C0FF; LW 0x100 -> 0x8040C0FF. Each load has a single mem_rd pulse with mem_addr=0x100.
- Misaligned and illegal requests: LW 0x102, LH 0x101, and op=011 each give done=1, err=1 in cycle s+1. mem_rd stays 0 and result keeps its previous value (0x8040C0FF).
- MEM_LAT=4: LW 0x200 (mem=0x12345678) -> busy for 6 cycles, done in cycle s+6, result=0x12345678. A start pulse during WAIT is ignored, and no second mem_rd appears.
- MEM_LAT=4: assert reset_n=0 mid-WAIT. All outputs go to 0 asynchronously, no done follows, and after release a new LB 0x103 (mem=0x7F000000) returns 0x0000007F.
- Back-to-back: start held high continuously gives loads completing every MEM_LAT+3 cycles with one IDLE gap each, and one done pulse per load.
